// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed seven-segment driver.
//   HEX_TABLE  - active-low g..a patterns for hex digits 0..F
//   SEG_BLANK  - all segments dark
//   GUARD_LEN  - prescaler values at slot start with all anodes off (ghosting guard)
//   BLINK_BITS - blink phase counter width (phase toggles every 2^BLINK_BITS cycles)
package seg7_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned GUARD_LEN  = 4;
    localparam int unsigned BLINK_BITS = 23;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Index 0 is the right-most element of the concatenation.
    localparam logic [15:0][SEG_W-1:0] HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_mux_driver_if.sv
// seg7_mux_driver_if: register write bus of the seven-segment driver.
//   iWR        - load strobe for iDIG / iDP / iBLANK (and iBLINK when SEG7_BLINK_EN)
//   iDIG       - hex nibbles, digit k at [4k+3:4k]
//   iDP        - decimal point enables, 1 = lit
//   iBLANK     - blank mask, 1 = digit dark
//   iBRIGHT_WR - load strobe for iBRIGHT
//   iBRIGHT    - PWM brightness level
//   iBLINK     - blink mask (only with SEG7_BLINK_EN)
// Modports: master drives the bus, slave (the driver) receives it.
interface seg7_mux_driver_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned PWM_BITS   = 4
);

    logic                      iWR;
    logic [4*NUM_DIGITS-1:0]   iDIG;
    logic [NUM_DIGITS-1:0]     iDP;
    logic [NUM_DIGITS-1:0]     iBLANK;
    logic                      iBRIGHT_WR;
    logic [PWM_BITS-1:0]       iBRIGHT;
`ifdef SEG7_BLINK_EN
    logic [NUM_DIGITS-1:0]     iBLINK;

    modport master (output iWR, iDIG, iDP, iBLANK, iBRIGHT_WR, iBRIGHT, iBLINK);
    modport slave  (input  iWR, iDIG, iDP, iBLANK, iBRIGHT_WR, iBRIGHT, iBLINK);
`else
    modport master (output iWR, iDIG, iDP, iBLANK, iBRIGHT_WR, iBRIGHT);
    modport slave  (input  iWR, iDIG, iDP, iBLANK, iBRIGHT_WR, iBRIGHT);
`endif

endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low g..a segment pattern.
//   iNIB    - 4-bit hex value
//   oSEG_c  - 7-bit segment pattern
module seg7_hex_decode (
    input  logic [3:0] iNIB,
    output logic [6:0] oSEG_c
);
    import seg7_pkg::*;

    assign oSEG_c = HEX_TABLE[iNIB];

endmodule

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: hex digit register file with static per-digit decode and a
// time-multiplexed, PWM-dimmed scanned output.
//   iCLK, iRST_N - clock, asynchronous active-low reset
//   bus          - write bus (seg7_mux_driver_if.slave)
//   oSEG_ALL     - static active-low segments, digit k at [7k+6:7k] (combinational)
//   oSEG, oDP    - scanned segments / decimal point, active-low, registered
//   oAN          - scanned anode select, active-low, registered
// Optional feature: define SEG7_BLINK_EN to add the bus.iBLINK mask and blink phase.
module seg7_mux_driver #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    seg7_mux_driver_if.slave        bus,
    output logic [7*NUM_DIGITS-1:0] oSEG_ALL,
    output logic [6:0]              oSEG,
    output logic                    oDP,
    output logic [NUM_DIGITS-1:0]   oAN
);
    import seg7_pkg::*;

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] rDIG;
    logic [NUM_DIGITS-1:0]   rDP;
    logic [NUM_DIGITS-1:0]   rBLANK;
    logic [PWM_BITS-1:0]     rBRIGHT;

    logic [PRE_W-1:0]        rPre;
    logic [IDX_W-1:0]        rIdx;
    logic [PWM_BITS-1:0]     rPwm;

    logic [NUM_DIGITS-1:0]   effBlank;
    logic [3:0]              digNib [NUM_DIGITS];
    logic [3:0]              curNib;
    logic [6:0]              curSeg;
    logic                    preWrap;
    logic                    inGuard;
    logic                    pwmOn;
    logic                    curBlank;
    logic                    anOn;

    // Register file: both strobes may land in the same cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rDIG    <= '0;
            rDP     <= '0;
            rBLANK  <= '0;
            rBRIGHT <= '1;
        end else begin
            if (bus.iWR) begin
                rDIG   <= bus.iDIG;
                rDP    <= bus.iDP;
                rBLANK <= bus.iBLANK;
            end
            if (bus.iBRIGHT_WR) begin
                rBRIGHT <= bus.iBRIGHT;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    logic [NUM_DIGITS-1:0] rBLINK;
    logic [BLINK_BITS-1:0] rBlinkCnt;
    logic                  rPhase;

    // Blink mask and phase; phase flips each time the counter rolls over.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rBLINK    <= '0;
            rBlinkCnt <= '0;
            rPhase    <= 1'b0;
        end else begin
            if (bus.iWR) begin
                rBLINK <= bus.iBLINK;
            end
            rBlinkCnt <= rBlinkCnt + 1'b1;
            if (&rBlinkCnt) begin
                rPhase <= ~rPhase;
            end
        end
    end

    assign effBlank = rBLANK | (rBLINK & {NUM_DIGITS{rPhase}});
`else
    assign effBlank = rBLANK;
`endif

    // Static decode, one decoder per digit.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : gDigit
        logic [6:0] segK;
        assign digNib[k] = rDIG[4*k +: 4];
        seg7_hex_decode uDec (
            .iNIB   (digNib[k]),
            .oSEG_c (segK)
        );
        assign oSEG_ALL[7*k +: 7] = effBlank[k] ? SEG_BLANK : segK;
    end

    // Scan path decoder for the currently selected digit.
    assign curNib = digNib[rIdx];

    seg7_hex_decode uScanDec (
        .iNIB   (curNib),
        .oSEG_c (curSeg)
    );

    always_comb begin
        preWrap  = (rPre == PRE_W'(SCAN_DIV - 1));
        inGuard  = (rPre < PRE_W'(GUARD_LEN));
        // All-ones brightness bypasses the compare so the digit never goes dark.
        pwmOn    = (&rBRIGHT) | (rPwm < rBRIGHT);
        curBlank = effBlank[rIdx];
        anOn     = !inGuard && pwmOn && !curBlank;
    end

    // Prescaler, digit index and PWM counter; register writes never disturb them.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rPre <= '0;
            rIdx <= '0;
            rPwm <= '0;
        end else begin
            rPwm <= rPwm + 1'b1;
            if (preWrap) begin
                rPre <= '0;
                rIdx <= (rIdx == IDX_W'(NUM_DIGITS - 1)) ? '0 : rIdx + 1'b1;
            end else begin
                rPre <= rPre + 1'b1;
            end
        end
    end

    // Registered scan outputs, one cycle behind the counters.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oAN  <= '1;
            oSEG <= SEG_BLANK;
            oDP  <= 1'b1;
        end else begin
            oAN  <= anOn ? ~(NUM_DIGITS'(1) << rIdx) : '1;
            oSEG <= curBlank ? SEG_BLANK : curSeg;
            oDP  <= ~(rDP[rIdx] & ~curBlank);
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver: randomized self-checking bench for seg7_mux_driver
// (NUM_DIGITS=8, SCAN_DIV=8, PWM_BITS=4) against a cycle-count based model.
`timescale 1ns/1ps
module tb_seg7_mux_driver;

    localparam int unsigned ND = 8;
    localparam int unsigned SD = 8;
    localparam int unsigned PB = 4;
    localparam int unsigned PWM_MAX = (1 << PB) - 1;

    logic            iCLK = 1'b0;
    logic            iRST_N;
    logic [7*ND-1:0] oSEG_ALL;
    logic [6:0]      oSEG;
    logic            oDP;
    logic [ND-1:0]   oAN;

    seg7_mux_driver_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus ();

    seg7_mux_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .PWM_BITS(PB)) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .bus      (bus),
        .oSEG_ALL (oSEG_ALL),
        .oSEG     (oSEG),
        .oDP      (oDP),
        .oAN      (oAN)
    );

    always #5 iCLK = ~iCLK;

    logic [6:0] hexTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: register contents and cycles elapsed since reset release.
    logic [3:0]      mDig [ND];
    logic [ND-1:0]   mDp;
    logic [ND-1:0]   mBlank;
    int              mBright;
    int              cyc;

    logic [ND-1:0]   expAn;
    logic [6:0]      expSeg;
    logic            expDp;
    logic [7*ND-1:0] expSegAll;

    int nChecks = 0;
    int nFails  = 0;

    task automatic model_reset();
        for (int k = 0; k < ND; k++) mDig[k] = 4'h0;
        mDp     = '0;
        mBlank  = '0;
        mBright = PWM_MAX;
        cyc     = 0;
        for (int k = 0; k < ND; k++) expSegAll[7*k +: 7] = hexTab[0];
    endtask

    // Advance one clock: predict the registered outputs from the pre-edge
    // state, then apply any writes on the bus to the model.
    task automatic tick();
        int pre;
        int idx;
        int pwm;
        bit lit;
        pre = cyc % SD;
        idx = (cyc / SD) % ND;
        pwm = cyc % (PWM_MAX + 1);
        lit = (mBright == PWM_MAX) || (pwm < mBright);
        expAn = '1;
        if (pre >= 4 && lit && !mBlank[idx]) expAn[idx] = 1'b0;
        expSeg = hexTab[mDig[idx]];
        expDp  = ~mDp[idx];
        if (bus.iWR) begin
            for (int k = 0; k < ND; k++) mDig[k] = bus.iDIG[4*k +: 4];
            mDp    = bus.iDP;
            mBlank = bus.iBLANK;
        end
        if (bus.iBRIGHT_WR) mBright = int'(bus.iBRIGHT);
        for (int k = 0; k < ND; k++) expSegAll[7*k +: 7] = mBlank[k] ? 7'h7F : hexTab[mDig[k]];
        cyc++;
        @(posedge iCLK);
        #1;
    endtask

    task automatic test_reset();
        iRST_N         = 1'b0;
        bus.iWR        = 1'b1;
        bus.iDIG       = 32'hFFFF_FFFF;
        bus.iDP        = '1;
        bus.iBLANK     = '1;
        bus.iBRIGHT_WR = 1'b1;
        bus.iBRIGHT    = 4'h3;
`ifdef SEG7_BLINK_EN
        bus.iBLINK     = '0;
`endif
        repeat (3) @(posedge iCLK);
        #1;
        nChecks++; if (oAN !== 8'hFF) begin nFails++; $display("FAIL reset_an got %h exp ff", oAN); end
        nChecks++; if (oSEG !== 7'h7F) begin nFails++; $display("FAIL reset_seg got %h exp 7f", oSEG); end
        nChecks++; if (oDP !== 1'b1) begin nFails++; $display("FAIL reset_dp got %b exp 1", oDP); end
        nChecks++; if (oSEG_ALL !== {ND{7'h40}}) begin nFails++; $display("FAIL reset_seg_all got %h exp %h", oSEG_ALL, {ND{7'h40}}); end
        @(negedge iCLK);
        iRST_N         = 1'b1;
        bus.iWR        = 1'b0;
        bus.iBRIGHT_WR = 1'b0;
        model_reset();
        tick();
        nChecks++; if (oSEG_ALL !== expSegAll) begin nFails++; $display("FAIL reset_write_ignored got %h exp %h", oSEG_ALL, expSegAll); end
        nChecks++; if (oAN !== 8'hFF) begin nFails++; $display("FAIL release_guard got %h exp ff", oAN); end
    endtask

    task automatic test_decode();
        bus.iDIG = 32'h76543210; bus.iDP = '0; bus.iBLANK = '0; bus.iWR = 1'b1;
        tick();
        bus.iWR = 1'b0;
        nChecks++; if (oSEG_ALL[6:0] !== 7'h40) begin nFails++; $display("FAIL decode_d0 got %h exp 40", oSEG_ALL[6:0]); end
        nChecks++; if (oSEG_ALL[55:49] !== 7'h78) begin nFails++; $display("FAIL decode_d7 got %h exp 78", oSEG_ALL[55:49]); end
        bus.iDIG = 32'hFEDCBA98; bus.iWR = 1'b1;
        tick();
        bus.iWR = 1'b0;
        nChecks++; if (oSEG_ALL !== expSegAll) begin nFails++; $display("FAIL decode_high got %h exp %h", oSEG_ALL, expSegAll); end
    endtask

    task automatic test_scan_walk();
        logic [ND-1:0] seen [$];
        logic [ND-1:0] last;
        int lows;
        while (cyc % (SD * ND) != 0) tick();
        last = '1;
        lows = 0;
        for (int i = 0; i < 2 * SD * ND; i++) begin
            tick();
            nChecks++; if (oAN !== expAn) begin nFails++; $display("FAIL walk_an cyc=%0d got %h exp %h", cyc, oAN, expAn); end
            if (oAN !== 8'hFF) begin
                lows++;
                if (oAN !== last) seen.push_back(oAN);
                nChecks++; if (oSEG !== expSeg) begin nFails++; $display("FAIL walk_seg cyc=%0d got %h exp %h", cyc, oSEG, expSeg); end
            end
            last = oAN;
        end
        nChecks++; if (lows !== SD * ND) begin nFails++; $display("FAIL walk_duty got %0d exp %0d", lows, SD * ND); end
        nChecks++; if (seen.size() !== 2 * ND) begin nFails++; $display("FAIL walk_slots got %0d exp %0d", seen.size(), 2 * ND); end
        for (int i = 0; i < seen.size() && i < 2 * ND; i++) begin
            logic [ND-1:0] e;
            e = ~(ND'(1) << (i % ND));
            nChecks++; if (seen[i] !== e) begin nFails++; $display("FAIL walk_order i=%0d got %h exp %h", i, seen[i], e); end
        end
    endtask

    task automatic test_brightness();
        int levels [3] = '{4, 12, 0};
        for (int l = 0; l < 3; l++) begin
            int lows;
            bus.iBRIGHT = PB'(levels[l]); bus.iBRIGHT_WR = 1'b1;
            tick();
            bus.iBRIGHT_WR = 1'b0;
            lows = 0;
            for (int i = 0; i < 256; i++) begin
                tick();
                if (oAN !== 8'hFF) lows++;
                nChecks++; if (oAN !== expAn) begin nFails++; $display("FAIL pwm_an lvl=%0d cyc=%0d got %h exp %h", levels[l], cyc, oAN, expAn); end
            end
            if (levels[l] == 0) begin
                nChecks++; if (lows !== 0) begin nFails++; $display("FAIL pwm_dark got %0d lit exp 0", lows); end
            end
        end
        bus.iBRIGHT = 4'hF; bus.iBRIGHT_WR = 1'b1;
        tick();
        bus.iBRIGHT_WR = 1'b0;
    endtask

    task automatic test_blank_dp();
        bus.iDIG = 32'($urandom); bus.iDP = 8'h01; bus.iBLANK = 8'h02; bus.iWR = 1'b1;
        tick();
        bus.iWR = 1'b0;
        nChecks++; if (oSEG_ALL[13:7] !== 7'h7F) begin nFails++; $display("FAIL blank_static got %h exp 7f", oSEG_ALL[13:7]); end
        for (int i = 0; i < SD * ND + 8; i++) begin
            tick();
            nChecks++; if (oAN !== expAn) begin nFails++; $display("FAIL blank_an cyc=%0d got %h exp %h", cyc, oAN, expAn); end
            nChecks++; if (oAN[1] !== 1'b1) begin nFails++; $display("FAIL blank_sel1 cyc=%0d got %h exp bit1 high", cyc, oAN); end
            if (oAN === 8'hFE) begin
                nChecks++; if (oDP !== 1'b0) begin nFails++; $display("FAIL dp_d0 got %b exp 0", oDP); end
            end else if (oAN !== 8'hFF) begin
                nChecks++; if (oDP !== 1'b1) begin nFails++; $display("FAIL dp_other got %b exp 1", oDP); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.iWR        = ($urandom_range(0, 15) == 0);
            bus.iBRIGHT_WR = ($urandom_range(0, 31) == 0);
            bus.iDIG       = 32'($urandom);
            bus.iDP        = 8'($urandom);
            bus.iBLANK     = 8'($urandom) & 8'($urandom);
            bus.iBRIGHT    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            tick();
            nChecks++; if (oAN !== expAn) begin nFails++; $display("FAIL rand_an cyc=%0d got %h exp %h", cyc, oAN, expAn); end
            nChecks++; if (oSEG_ALL !== expSegAll) begin nFails++; $display("FAIL rand_seg_all cyc=%0d got %h exp %h", cyc, oSEG_ALL, expSegAll); end
            if (expAn !== 8'hFF) begin
                nChecks++; if (oSEG !== expSeg) begin nFails++; $display("FAIL rand_seg cyc=%0d got %h exp %h", cyc, oSEG, expSeg); end
                nChecks++; if (oDP !== expDp) begin nFails++; $display("FAIL rand_dp cyc=%0d got %b exp %b", cyc, oDP, expDp); end
            end
        end
        bus.iWR = 1'b0;
        bus.iBRIGHT_WR = 1'b0;
    endtask

    task automatic test_reset_midslot();
        logic [ND-1:0] first;
        bus.iBLANK = '0; bus.iDIG = 32'h89ABCDEF; bus.iWR = 1'b1;
        tick();
        bus.iWR = 1'b0;
        while (cyc % SD != 5) tick();
        bus.iDIG = 32'h12345678; bus.iWR = 1'b1;
        #3;
        iRST_N = 1'b0;
        #1;
        nChecks++; if (oAN !== 8'hFF) begin nFails++; $display("FAIL midrst_an got %h exp ff", oAN); end
        nChecks++; if (oSEG !== 7'h7F) begin nFails++; $display("FAIL midrst_seg got %h exp 7f", oSEG); end
        nChecks++; if (oDP !== 1'b1) begin nFails++; $display("FAIL midrst_dp got %b exp 1", oDP); end
        nChecks++; if (oSEG_ALL !== {ND{7'h40}}) begin nFails++; $display("FAIL midrst_seg_all got %h exp %h", oSEG_ALL, {ND{7'h40}}); end
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;
        bus.iWR = 1'b0;
        model_reset();
        first = '1;
        for (int i = 0; i < SD * ND; i++) begin
            tick();
            if (first === 8'hFF && oAN !== 8'hFF) first = oAN;
            nChecks++; if (oAN !== expAn) begin nFails++; $display("FAIL restart_an cyc=%0d got %h exp %h", cyc, oAN, expAn); end
            nChecks++; if (oSEG_ALL !== expSegAll) begin nFails++; $display("FAIL restart_seg_all got %h exp %h", oSEG_ALL, expSegAll); end
        end
        nChecks++; if (first !== 8'hFE) begin nFails++; $display("FAIL restart_first got %h exp fe", first); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_scan_walk();
        test_brightness();
        test_blank_dp();
        test_random();
        test_reset_midslot();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
